lock_ctrl: RTL and testbench
============================

# lock_ctrl

Top-level sequencer for the 3-digit password lock. It drives `current_state` into the digit-entry block, which captures digits only in states 1 and 3 and clears on `set_password`/`test`. It also stores the password, compares entries, and drives the unlock/fail/alarm indicators. It owns the failure counter and the entry-timeout/hold timer.

## Interface
Parameters:
- HOLD_CYCLES, 100_000_000: cycles `unlock`/`fail` are held (1 s @ 100 MHz).
- TIMEOUT_CYCLES, 500_000_000: entry inactivity timeout.
- MAX_FAIL, 3: consecutive failures before alarm; legal range 1..3.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- set_password  in  1  single-cycle pulse, debounced upstream.
- test  in  1  single-cycle pulse.
- confirm  in  1  single-cycle pulse that ends entry.
- num7, num6, num5  in  2 each  captured digits from the entry block; 0 = empty, 1..3 valid.
- current_state  out  5  state code; also drives the entry block.
- pwd_set  out  1  a password has been stored.
- unlock  out  1  open indicator.
- fail  out  1  wrong-entry indicator.
- alarm  out  1  lockout indicator.
- fail_cnt  out  2  consecutive failures, saturating at 3.

## Operation
- State codes: IDLE=0, SET=1, SAVE=2, TEST=3, CHECK=4, OPEN=5, FAIL=6, ALARM=7. Codes 8..31 are illegal and return to IDLE on the next edge.
- "complete" means num7, num6 and num5 are all nonzero.
- IDLE:
  - `set_password` with !pwd_set → SET.
  - `test` with pwd_set → TEST.
  - All other pulses are ignored.
- SET:
  - `confirm` with complete → SAVE.
  - `confirm` with incomplete input is ignored.
  - `set_password` restarts entry: stay in SET and reload the timer.
  - Timeout → IDLE.
- SAVE, one cycle: password ← {num7,num6,num5}, pwd_set ← 1, fail_cnt ← 0, next state IDLE.
- TEST:
  - `confirm` with complete → CHECK.
  - `test` restarts entry.
  - Timeout → IDLE.
- CHECK, one cycle:
  - Match → OPEN and fail_cnt ← 0.
  - Mismatch → FAIL and fail_cnt ← min(fail_cnt+1, 3).
- OPEN:
  - unlock=1 until the hold expires, then → IDLE.
  - `set_password` → SET. Changing the password after the first set is only possible from OPEN.
- FAIL:
  - fail=1 for the hold.
  - On expiry: → ALARM if fail_cnt ≥ MAX_FAIL, otherwise → IDLE.
- ALARM: alarm=1; exited only by reset.
- Simultaneous events: `set_password` beats `test`, and `test` beats `confirm`.
- Timer (32-bit):
  - Cleared on every state change.
  - In SET/TEST, also cleared on any change of {num7,num6,num5}.
  - Timeout means timer == TIMEOUT_CYCLES-1; hold expiry means timer == HOLD_CYCLES-1.
- unlock, fail and alarm are Moore decodes of the state register and are glitch-free (registered state only).

## Timing
- Reset values (asynchronous): state IDLE, password 0, pwd_set 0, fail_cnt 0, unlock 0, fail 0, alarm 0, timer 0.
- Reset asserted mid-operation (including in ALARM) forces all of the above immediately.
- State transitions: a pulse sampled at edge k changes `current_state` after edge k.
- Latency from `confirm` to unlock/fail: `confirm` at edge k → CHECK after k → OPEN/FAIL after k+1. The indicator is high for exactly HOLD_CYCLES cycles.
- SAVE occupies exactly one cycle; pwd_set is visible the cycle IDLE is re-entered.

## Configuration
- LOCK_ALARM_EN defined: ALARM is reachable as specified above.
- LOCK_ALARM_EN undefined:
  - FAIL always returns to IDLE.
  - alarm is tied to 0 and ALARM is never entered.
  - fail_cnt still counts and saturates.

## Structure
- Package lock_pkg holds:
  - state code localparams (5-bit);
  - DIGIT_W=2 and PWD_W=6;
  - the EMPTY digit code 0.
- Sub-module lock_timer holds the 32-bit up-counter. It has a `clr` input and compare outputs `hold_done` and `timeout`, and is instantiated once.

## Test plan
All scenarios use HOLD_CYCLES=4, TIMEOUT_CYCLES=20, MAX_FAIL=3.
- Set password: reset; pulse set_password, digits 2,1,3, confirm → state 1→2→0, pwd_set=1, fail_cnt=0.
- Correct test: after the set above, pulse test, digits 2,1,3, confirm → CHECK then OPEN, unlock high for 4 cycles, then IDLE.
- Wrong ×3: digits 1,1,1 confirmed three times → fail high 4 cycles each, fail_cnt 1,2,3, then state 7 with alarm=1. Without LOCK_ALARM_EN: state 0, alarm=0.
- Incomplete and timeout: in TEST, digits 3,2 only, then confirm → stays 3; no digit change for 20 cycles → IDLE.
- Priority and guards:
  - set_password with test in IDLE when pwd_set=1 → ignored, stays 0.
  - set_password during OPEN → SET.
  - test in IDLE with pwd_set=0 → ignored.
- Reset mid-FAIL: drop rst during FAIL → all outputs 0 and state 0 immediately, pwd_set=0.

Source files
------------

// File: rtl/lock_pkg.sv
// lock_pkg: shared constants for the 3-digit password lock.
// State codes, digit/password widths and the entry-completeness helper.
package lock_pkg;

  localparam int DIGIT_W = 2;
  localparam int PWD_W   = 6;
  localparam int STATE_W = 5;

  localparam logic [DIGIT_W-1:0] EMPTY = '0;

  localparam logic [STATE_W-1:0] S_IDLE  = 5'd0;
  localparam logic [STATE_W-1:0] S_SET   = 5'd1;
  localparam logic [STATE_W-1:0] S_SAVE  = 5'd2;
  localparam logic [STATE_W-1:0] S_TEST  = 5'd3;
  localparam logic [STATE_W-1:0] S_CHECK = 5'd4;
  localparam logic [STATE_W-1:0] S_OPEN  = 5'd5;
  localparam logic [STATE_W-1:0] S_FAIL  = 5'd6;
  localparam logic [STATE_W-1:0] S_ALARM = 5'd7;

  function automatic logic is_complete(
    input logic [PWD_W-1:0] d
  );
    return (d[5:4] != EMPTY) &&
           (d[3:2] != EMPTY) &&
           (d[1:0] != EMPTY);
  endfunction

endpackage

// File: rtl/lock_ctrl_if.sv
// lock_ctrl_if: lock sequencer bus (pulses, digits, state, indicators).
// master drives pulses/digits; slave (lock_ctrl) drives state/indicators.
interface lock_ctrl_if;
  import lock_pkg::*;

  logic               set_password;
  logic               test;
  logic               confirm;
  logic [DIGIT_W-1:0] num7;
  logic [DIGIT_W-1:0] num6;
  logic [DIGIT_W-1:0] num5;
  logic [STATE_W-1:0] current_state;
  logic               pwd_set;
  logic               unlock;
  logic               fail;
  logic               alarm;
  logic [1:0]         fail_cnt;

  modport master (
    output set_password, test, confirm,
    output num7, num6, num5,
    input  current_state, pwd_set,
    input  unlock, fail, alarm, fail_cnt
  );

  modport slave (
    input  set_password, test, confirm,
    input  num7, num6, num5,
    output current_state, pwd_set,
    output unlock, fail, alarm, fail_cnt
  );

endinterface

// File: rtl/lock_timer.sv
// lock_timer: 32-bit up-counter shared by entry timeout and hold.
// Ports: clk, rst (async active-low), clr in; hold_done, timeout out.
module lock_timer #(
  parameter int unsigned HOLD_CYCLES    = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic hold_done,
  output logic timeout
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign cnt_d = clr ? '0 : cnt_q + 32'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hold_done = (cnt_q == HOLD_CYCLES - 32'd1);
  assign timeout   = (cnt_q == TIMEOUT_CYCLES - 32'd1);

endmodule

// File: rtl/lock_ctrl.sv
// lock_ctrl: password lock sequencer, password store and indicators.
// Ports: clk, rst (async active-low), bus (lock_ctrl_if.slave).
// Build option: LOCK_ALARM_EN makes ALARM reachable after MAX_FAIL.
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned MAX_FAIL       = 3
) (
  input  logic        clk,
  input  logic        rst,
  lock_ctrl_if.slave  bus
);

`ifdef LOCK_ALARM_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif

  logic [STATE_W-1:0] state_q, state_d;
  logic [PWD_W-1:0]   pwd_q, pwd_d;
  logic               pwd_set_q, pwd_set_d;
  logic [1:0]         fcnt_q, fcnt_d;
  logic [PWD_W-1:0]   dig_q;
  logic               unlock_q, fail_q, alarm_q;

  logic [PWD_W-1:0] digs;
  logic             sp, tp, cf;
  logic             cpl;
  logic             restart;
  logic             entry;
  logic             dig_chg;
  logic             clr;
  logic             hold_done;
  logic             timeout;

  assign digs = {bus.num7, bus.num6, bus.num5};
  assign cpl  = is_complete(digs);

  // set_password beats test, test beats confirm
  assign sp = bus.set_password;
  assign tp = bus.test && !sp;
  assign cf = bus.confirm && !sp && !bus.test;

  always_comb begin
    state_d   = state_q;
    pwd_d     = pwd_q;
    pwd_set_d = pwd_set_q;
    fcnt_d    = fcnt_q;
    restart   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sp && !pwd_set_q) begin
          state_d = S_SET;
        end else if (tp && pwd_set_q) begin
          state_d = S_TEST;
        end
      end
      S_SET: begin
        if (sp) begin
          restart = 1'b1;
        end else if (cf && cpl) begin
          state_d = S_SAVE;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_SAVE: begin
        pwd_d     = digs;
        pwd_set_d = 1'b1;
        fcnt_d    = 2'd0;
        state_d   = S_IDLE;
      end
      S_TEST: begin
        if (tp) begin
          restart = 1'b1;
        end else if (cf && cpl) begin
          state_d = S_CHECK;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (digs == pwd_q) begin
          state_d = S_OPEN;
          fcnt_d  = 2'd0;
        end else begin
          state_d = S_FAIL;
          fcnt_d  = (fcnt_q == 2'd3) ?
                    2'd3 : fcnt_q + 2'd1;
        end
      end
      S_OPEN: begin
        if (sp) begin
          state_d = S_SET;
        end else if (hold_done) begin
          state_d = S_IDLE;
        end
      end
      S_FAIL: begin
        if (hold_done) begin
          if (ALARM_EN &&
              (32'(fcnt_q) >= MAX_FAIL)) begin
            state_d = S_ALARM;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ALARM: begin
        state_d = S_ALARM;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // any digit movement during entry counts as activity
  assign entry   = (state_q == S_SET) ||
                   (state_q == S_TEST);
  assign dig_chg = entry && (digs != dig_q);
  assign clr     = (state_d != state_q) ||
                   restart || dig_chg;

  lock_timer #(
    .HOLD_CYCLES    (HOLD_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .hold_done (hold_done),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pwd_q     <= '0;
      pwd_set_q <= 1'b0;
      fcnt_q    <= 2'd0;
      dig_q     <= '0;
      unlock_q  <= 1'b0;
      fail_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwd_q     <= pwd_d;
      pwd_set_q <= pwd_set_d;
      fcnt_q    <= fcnt_d;
      dig_q     <= digs;
      // flopped decodes of next state track state_q exactly
      unlock_q  <= (state_d == S_OPEN);
      fail_q    <= (state_d == S_FAIL);
      alarm_q   <= ALARM_EN &&
                   (state_d == S_ALARM);
    end
  end

  assign bus.current_state = state_q;
  assign bus.pwd_set       = pwd_set_q;
  assign bus.fail_cnt      = fcnt_q;
  assign bus.unlock        = unlock_q;
  assign bus.fail          = fail_q;
  assign bus.alarm         = alarm_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// tb_lock_ctrl: directed self-checking bench for lock_ctrl.
// Runs with HOLD=4, TIMEOUT=20, MAX_FAIL=3; honours LOCK_ALARM_EN.
module tb_lock_ctrl;
  import lock_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  lock_ctrl_if bus ();

  lock_ctrl #(
    .HOLD_CYCLES    (4),
    .TIMEOUT_CYCLES (20),
    .MAX_FAIL       (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  task automatic chk_st(input string tag,
                        input logic [4:0] e);
    chk(tag, 32'(bus.current_state), 32'(e));
  endtask

  task automatic chk_b(input string tag,
                       input logic g,
                       input logic e);
    chk(tag, 32'(g), 32'(e));
  endtask

  task automatic chk_fc(input string tag,
                        input logic [1:0] e);
    chk(tag, 32'(bus.fail_cnt), 32'(e));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic digs(input logic [1:0] a,
                      input logic [1:0] b,
                      input logic [1:0] c);
    bus.num7 = a;
    bus.num6 = b;
    bus.num5 = c;
  endtask

  task automatic set_pwd(input logic [1:0] a,
                         input logic [1:0] b,
                         input logic [1:0] c);
    bus.set_password = 1'b1;
    digs(2'd0, 2'd0, 2'd0);
    tick;
    bus.set_password = 1'b0;
    chk_st("set_enter", S_SET);
    digs(a, 2'd0, 2'd0);
    tick;
    digs(a, b, 2'd0);
    tick;
    digs(a, b, c);
    tick;
    bus.confirm = 1'b1;
    tick;
    bus.confirm = 1'b0;
    chk_st("save_state", S_SAVE);
    tick;
    chk_st("save_idle", S_IDLE);
    chk_b("pwd_set", bus.pwd_set, 1'b1);
    chk_fc("save_fcnt", 2'd0);
  endtask

  task automatic do_test(input logic [1:0] a,
                         input logic [1:0] b,
                         input logic [1:0] c);
    bus.test = 1'b1;
    digs(2'd0, 2'd0, 2'd0);
    tick;
    bus.test = 1'b0;
    chk_st("test_enter", S_TEST);
    digs(a, b, c);
    tick;
    bus.confirm = 1'b1;
    tick;
    bus.confirm = 1'b0;
    chk_st("check_state", S_CHECK);
  endtask

  initial begin
    bus.set_password = 1'b0;
    bus.test         = 1'b0;
    bus.confirm      = 1'b0;
    digs(2'd0, 2'd0, 2'd0);
    repeat (3) tick;

    chk_st("rst_state", S_IDLE);
    chk_b("rst_pwd_set", bus.pwd_set, 1'b0);
    chk_fc("rst_fcnt", 2'd0);
    chk_b("rst_unlock", bus.unlock, 1'b0);
    chk_b("rst_fail", bus.fail, 1'b0);
    chk_b("rst_alarm", bus.alarm, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick;

    bus.test = 1'b1;
    tick;
    bus.test = 1'b0;
    chk_st("test_nopwd", S_IDLE);

    set_pwd(2'd2, 2'd1, 2'd3);

    bus.set_password = 1'b1;
    bus.test         = 1'b1;
    tick;
    bus.set_password = 1'b0;
    bus.test         = 1'b0;
    chk_st("sp_tp_ignored", S_IDLE);

    do_test(2'd2, 2'd1, 2'd3);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk_st("open_state", S_OPEN);
      chk_b("open_unlock", bus.unlock, 1'b1);
      tick;
    end
    chk_st("open_done", S_IDLE);
    chk_b("open_unlock_off", bus.unlock, 1'b0);
    chk_fc("open_fcnt", 2'd0);

    do_test(2'd2, 2'd1, 2'd3);
    tick;
    chk_st("open2", S_OPEN);
    bus.set_password = 1'b1;
    digs(2'd0, 2'd0, 2'd0);
    tick;
    bus.set_password = 1'b0;
    chk_st("open_to_set", S_SET);
    chk_b("set_unlock_off", bus.unlock, 1'b0);
    digs(2'd3, 2'd3, 2'd1);
    tick;
    bus.confirm = 1'b1;
    tick;
    bus.confirm = 1'b0;
    chk_st("resave", S_SAVE);
    tick;
    chk_st("resave_idle", S_IDLE);

    do_test(2'd3, 2'd3, 2'd1);
    tick;
    chk_b("newpwd_unlock", bus.unlock, 1'b1);
    repeat (4) tick;
    chk_st("newpwd_idle", S_IDLE);

    bus.test = 1'b1;
    digs(2'd0, 2'd0, 2'd0);
    tick;
    bus.test = 1'b0;
    chk_st("tmo_enter", S_TEST);
    digs(2'd3, 2'd0, 2'd0);
    tick;
    digs(2'd3, 2'd2, 2'd0);
    tick;
    bus.confirm = 1'b1;
    tick;
    bus.confirm = 1'b0;
    chk_st("incomplete", S_TEST);
    repeat (18) tick;
    chk_st("tmo_last", S_TEST);
    tick;
    chk_st("timeout", S_IDLE);

    for (int k = 1; k <= 3; k++) begin
      do_test(2'd1, 2'd1, 2'd1);
      tick;
      chk_fc("wrong_fcnt", 2'(k));
      for (int i = 0; i < 4; i++) begin
        chk_st("fail_state", S_FAIL);
        chk_b("fail_ind", bus.fail, 1'b1);
        tick;
      end
      chk_b("fail_off", bus.fail, 1'b0);
      if (k < 3) begin
        chk_st("fail_idle", S_IDLE);
      end
    end
`ifdef LOCK_ALARM_EN
    chk_st("alarm_state", S_ALARM);
    chk_b("alarm_on", bus.alarm, 1'b1);
    bus.test = 1'b1;
    tick;
    bus.test = 1'b0;
    repeat (3) tick;
    chk_st("alarm_stuck", S_ALARM);
`else
    chk_st("noalarm_idle", S_IDLE);
    chk_b("noalarm_off", bus.alarm, 1'b0);
    do_test(2'd1, 2'd1, 2'd1);
    tick;
    chk_fc("fcnt_sat", 2'd3);
    repeat (4) tick;
    chk_st("noalarm_idle2", S_IDLE);
    chk_b("noalarm_off2", bus.alarm, 1'b0);
`endif

    #2 rst = 1'b0;
    #1;
    chk_st("arst_state", S_IDLE);
    chk_b("arst_alarm", bus.alarm, 1'b0);
    chk_b("arst_pwd_set", bus.pwd_set, 1'b0);
    chk_fc("arst_fcnt", 2'd0);
    @(negedge clk);
    rst = 1'b1;
    tick;

    set_pwd(2'd2, 2'd1, 2'd3);
    do_test(2'd1, 2'd1, 2'd1);
    tick;
    chk_st("mid_fail", S_FAIL);
    tick;
    chk_b("mid_fail_ind", bus.fail, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_st("rfail_state", S_IDLE);
    chk_b("rfail_fail", bus.fail, 1'b0);
    chk_b("rfail_unlock", bus.unlock, 1'b0);
    chk_b("rfail_alarm", bus.alarm, 1'b0);
    chk_b("rfail_pwd_set", bus.pwd_set, 1'b0);
    chk_fc("rfail_fcnt", 2'd0);
    @(negedge clk);
    rst = 1'b1;
    tick;
    chk_st("post_rst", S_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
